// File: rtl/rr_mux_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_if
// Bundles the request side (per-channel valid/data/ready) and the registered
// output side (valid/data/channel/ready) of rr_mux_arbiter.
//   in_valid  [NUM_CH]        producer requests, bit i = channel i
//   in_data   [NUM_CH*WIDTH]  flattened words, channel i at [i*WIDTH +: WIDTH]
//   in_ready  [NUM_CH]        one-hot (or zero) accept back to producers
//   out_valid / out_data / out_ch   registered selected word and its source
//   out_ready                 consumer accepts the held word
// master: producers + consumer side; slave: the arbiter itself.
// -----------------------------------------------------------------------------
interface rr_mux_arbiter_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_ready;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic [CH_W-1:0]         out_ch;
    logic                    out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
// N-channel registered multiplexer with built-in arbitration. Each cycle the
// output register can load (empty, or being drained) one requesting channel is
// granted, its word is captured together with its channel index.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_mux_arbiter_if.slave (see interface header for the signal list)
// Parameters: WIDTH word width, NUM_CH channel count (2..16),
//             RR 1 = round-robin, 0 = fixed priority (lowest index wins).
// -----------------------------------------------------------------------------
module rr_mux_arbiter #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int RR     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_arbiter_if.slave  bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW1  = CH_W + 1;
    // One extra bit so ptr + offset can exceed NUM_CH-1 before wrapping.
    localparam logic [CH_W:0] LAST_IDX = CW1'(NUM_CH - 1);
    localparam logic [CH_W:0] NUM_CH_W = CW1'(NUM_CH);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic [WIDTH-1:0]  ch_data [NUM_CH];
    logic              load_en;
    logic              grant_found;
    logic              grant_fire;
    logic [CH_W-1:0]   grant_idx;

    // Unpack the flat data bus and drive the one-hot accept.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_data[gi]     = bus.in_data[gi*WIDTH +: WIDTH];
        assign bus.in_ready[gi] = grant_fire && (grant_idx == CH_W'(gi));
    end

    assign load_en = (state_q == EMPTY) || bus.out_ready;
    // rst_n gates the grant so nothing is accepted while reset is held.
    assign grant_fire = rst_n && load_en && grant_found;

    // Search from ptr upward, wrapping at NUM_CH (not at 2^CH_W). With RR=0
    // the pointer is pinned at 0, which turns this into lowest-index-wins.
    always_comb begin
        logic [CH_W:0] cand;
        cand        = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            cand = {1'b0, ptr_q} + CW1'(j);
            if (cand > LAST_IDX) begin
                cand = cand - NUM_CH_W;
            end
            if (!grant_found && bus.in_valid[cand[CH_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[CH_W-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (grant_fire) begin
            state_d = FULL;
            data_d  = ch_data[grant_idx];
            ch_d    = grant_idx;
            if (RR != 0) begin
                ptr_d = (grant_idx == LAST_IDX[CH_W-1:0]) ? '0 : grant_idx + 1'b1;
            end
        end else if (load_en) begin
            // Drained (or already empty) with nothing to refill.
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = (state_q == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
endmodule

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
// Three builds driven by one shared stimulus stream: NUM_CH=4 round-robin,
// NUM_CH=3 round-robin (non-power-of-2 wrap) and NUM_CH=4 fixed priority.
// A behavioural arbiter model predicts in_ready and the output register;
// granted words are pushed to a per-build queue and popped when consumed.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;
    localparam int NB = 3;
    localparam int NCH [NB] = '{4, 3, 4};
    localparam bit MRR [NB] = '{1'b1, 1'b1, 1'b0};

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.WIDTH(32), .NUM_CH(4)) if4 ();
    rr_mux_arbiter_if #(.WIDTH(32), .NUM_CH(3)) if3 ();
    rr_mux_arbiter_if #(.WIDTH(32), .NUM_CH(4)) iffp ();

    assign if4.in_valid   = in_valid;
    assign if4.in_data    = in_data;
    assign if4.out_ready  = out_ready;
    assign if3.in_valid   = in_valid[2:0];
    assign if3.in_data    = in_data[95:0];
    assign if3.out_ready  = out_ready;
    assign iffp.in_valid  = in_valid;
    assign iffp.in_data   = in_data;
    assign iffp.out_ready = out_ready;

    rr_mux_arbiter #(.WIDTH(32), .NUM_CH(4), .RR(1)) dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    rr_mux_arbiter #(.WIDTH(32), .NUM_CH(3), .RR(1)) dut3  (.clk(clk), .rst_n(rst_n), .bus(if3));
    rr_mux_arbiter #(.WIDTH(32), .NUM_CH(4), .RR(0)) dutfp (.clk(clk), .rst_n(rst_n), .bus(iffp));

    logic [3:0]  rdy [NB];
    logic        ov  [NB];
    logic [31:0] od  [NB];
    logic [1:0]  oc  [NB];

    assign rdy[0] = if4.in_ready;
    assign rdy[1] = {1'b0, if3.in_ready};
    assign rdy[2] = iffp.in_ready;
    assign ov[0]  = if4.out_valid;
    assign ov[1]  = if3.out_valid;
    assign ov[2]  = iffp.out_valid;
    assign od[0]  = if4.out_data;
    assign od[1]  = if3.out_data;
    assign od[2]  = iffp.out_data;
    assign oc[0]  = if4.out_ch;
    assign oc[1]  = if3.out_ch;
    assign oc[2]  = iffp.out_ch;

    // Model state per build.
    int          m_ptr [NB];
    logic        m_ov  [NB];
    logic [31:0] m_od  [NB];
    int          m_oc  [NB];
    logic [33:0] sbq   [NB][$];

    task automatic check(input string tag, input int b, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[b%0d]: observed %h expected %h", tag, b, got, exp);
        end
    endtask

    function automatic int pick(input int n, input bit rr, input int ptr, input logic [3:0] v);
        for (int j = 0; j < n; j++) begin
            int idx;
            idx = rr ? (ptr + j) % n : j;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < NB; b++) begin
            m_ptr[b] = 0;
            m_ov[b]  = 1'b0;
            m_od[b]  = '0;
            m_oc[b]  = 0;
            sbq[b].delete();
        end
    endtask

    task automatic set_default_data();
        for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
    endtask

    // Check the current cycle, advance the model, then step one clock.
    // Inputs are expected to be stable from posedge+1.
    task automatic cycle();
        #2;
        for (int b = 0; b < NB; b++) begin
            int g;
            logic le;
            logic [3:0] exp_rdy;
            logic [33:0] e;
            g = pick(NCH[b], MRR[b], m_ptr[b], in_valid);
            le = !m_ov[b] || out_ready;
            exp_rdy = (rst_n && le && g >= 0) ? 4'(1 << g) : 4'h0;
            check("in_ready", b, 64'(rdy[b]), 64'(exp_rdy));
            check("out_valid", b, 64'(ov[b]), 64'(m_ov[b]));
            check("out_data", b, 64'(od[b]), 64'(m_od[b]));
            check("out_ch", b, 64'(oc[b]), 64'(m_oc[b]));
            if (rst_n) begin
                if (m_ov[b] && out_ready) begin
                    if (sbq[b].size() == 0) begin
                        check("sb_underflow", b, 64'(ov[b]), 64'(0));
                    end else begin
                        e = sbq[b].pop_front();
                        check("sb_data", b, 64'(od[b]), 64'(e[31:0]));
                        check("sb_ch", b, 64'(oc[b]), 64'(e[33:32]));
                    end
                end
                if (le) begin
                    if (g >= 0) begin
                        sbq[b].push_back({2'(g), in_data[g*32 +: 32]});
                        m_ov[b]  = 1'b1;
                        m_od[b]  = in_data[g*32 +: 32];
                        m_oc[b]  = g;
                        m_ptr[b] = MRR[b] ? (g + 1) % NCH[b] : 0;
                    end else begin
                        m_ov[b] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with every channel requesting.
        rst_n = 1'b0;
        in_valid = 4'hF;
        out_ready = 1'b1;
        set_default_data();
        model_reset();
        cycle();
        cycle();

        // Release: all requesting, consumer always ready.
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // Backpressure: channel 2 delivers DEADBEEF, then consumer stalls.
        in_valid = 4'b0100;
        in_data[64 +: 32] = 32'hDEAD_BEEF;
        cycle();
        in_valid = 4'hF;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("stall_data", 0, 64'(if4.out_data), 64'h0000_0000_DEAD_BEEF);
        check("stall_ch", 0, 64'(if4.out_ch), 64'd2);
        set_default_data();
        out_ready = 1'b1;
        cycle();
        check("refill_ch", 0, 64'(if4.out_ch), 64'd3);

        // Move the rr4 pointer to 3, then only channels 1 and 3 request.
        in_valid = 4'b0100;
        cycle();
        in_valid = 4'b1010;
        cycle();
        cycle();
        in_valid = 4'hF;
        cycle();
        check("skip_ptr", 0, 64'(if4.out_ch), 64'd2);

        // Fixed-priority contention: channels 0 and 3.
        in_valid = 4'b1001;
        for (int i = 0; i < 4; i++) cycle();

        // Idle drain.
        in_valid = 4'b0000;
        cycle();
        cycle();
        check("drain_valid", 2, 64'(iffp.out_valid), 64'd0);
        check("drain_data", 2, 64'(iffp.out_data), 64'h0000_0000_A000_0000);

        // Random traffic.
        for (int i = 0; i < 60; i++) begin
            in_valid = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++) in_data[c*32 +: 32] = $urandom;
            cycle();
        end

        // Fill and stall, then reset asynchronously mid-cycle.
        in_valid = 4'hF;
        out_ready = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        for (int b = 0; b < NB; b++) begin
            check("arst_valid", b, 64'(ov[b]), 64'd0);
            check("arst_data", b, 64'(od[b]), 64'd0);
            check("arst_ch", b, 64'(oc[b]), 64'd0);
            check("arst_ready", b, 64'(rdy[b]), 64'd0);
        end
        model_reset();
        out_ready = 1'b1;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Parametrised N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes and built-in arbitration. It generalises the 2:1 datapath select into a channel merger: it picks one requesting source per cycle (round-robin or fixed priority), registers the selected word and reports which channel it came from. It sits wherever several producers (ALU result, memory read, immediate path, etc.) share a single downstream consumer in the datapath.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- NUM_CH, 4, number of input channels (2..16)
- RR, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)
- CH_W, derived = max(1, clog2(NUM_CH)), width of the channel-index output
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  NUM_CH  per-channel request; bit i belongs to channel i
- in_data  input  NUM_CH*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH]
- in_ready  output  NUM_CH  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  WIDTH  registered selected word
- out_ch  output  CH_W  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- One output register stage; state is EMPTY (out_valid=0) or FULL (out_valid=1).
- load_en = !out_valid | out_ready (register empty, or being drained this cycle).
- Grant: when load_en and any in_valid, exactly one channel g is granted; in_ready[g]=1, all others 0. No grant when load_en=0 or no in_valid; in_ready all 0.
- in_ready is combinational from in_valid, out_valid, out_ready and the priority pointer; never depends on in_data.
- On a grant: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
- load_en with no in_valid: out_valid <= 0; out_data and out_ch hold their last values.
- load_en=0: out_valid, out_data, out_ch hold (stable while out_valid & !out_ready).
- Round-robin (RR=1): pointer ptr (CH_W bits) names the highest-priority channel; search order ptr, ptr+1, ..., wrapping modulo NUM_CH. After grant g, ptr <= (g+1) mod NUM_CH (NUM_CH-1 wraps to 0). ptr changes only on a grant. Non-power-of-2 NUM_CH must wrap at NUM_CH, never at 2^CH_W.
- Fixed priority (RR=0): lowest-index requesting channel wins; ptr stays 0.
- A channel that deasserts in_valid before being granted is simply not considered; no request latching.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, out_data=0, out_ch=0, ptr=0; in_ready all 0 while rst_n=0 regardless of inputs. Reset mid-transfer discards the held word; no partial handshake completes.
- First rising edge after rst_n deasserts may already grant.
- Latency: input handshake at edge N -> out_valid=1 with that word after edge N (visible in cycle N+1).
- Throughput: one word per cycle when out_ready held high; drain and refill occur on the same edge with no bubble.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready all 0; out_data/out_ch unchanged until accepted.
- Simultaneous drain and empty inputs: out_valid falls on that edge.
- Round-robin fairness: with all channels requesting continuously and out_ready=1, each channel granted exactly once per NUM_CH cycles.

## Test plan
- Reset: drive in_valid all ones, out_ready=1, rst_n=0 -> in_ready=0, out_valid=0, out_data=0, out_ch=0; assert rst_n mid-stream with out_valid=1 -> outputs clear immediately, without a clock edge.
- Round-robin, NUM_CH=4, WIDTH=32: all in_valid=1, in_data[i]=0xA0000000+i, out_ready=1 -> out_ch sequence 0,1,2,3,0,1 with matching out_data, one per cycle.
- Backpressure: channel 2 sends 0xDEADBEEF, out_ready=0 for 3 cycles -> out_valid=1, out_data=0xDEADBEEF, out_ch=2 stable, in_ready all 0; out_ready=1 -> next grant on the same edge, no bubble.
- Skip/wrap: ptr=3, only channels 1 and 3 requesting -> grant 3 then 1, ptr ends at 2; NUM_CH=3 build: grant 2 wraps ptr to 0, never to 3.
- Fixed priority (RR=0): channels 0 and 3 requesting continuously -> channel 0 granted every cycle, in_ready[3]=0 throughout.
- Idle drain: single word accepted with no further in_valid -> out_valid drops the cycle after out_ready=1, out_data retains the last value.
